snn_load_ctrl: RTL and testbench
================================

SNN_LOAD_CTRL -- requirements
Module: snn_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 784, meaning the number of image bits loaded per inference (a multiple of 8, at most 1024).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the input-RAM address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, meaning 50 MHz system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port rx_rdy, input, 1, meaning a one-cycle strobe from the UART receiver that rx_data is valid.
REQ-007 SHALL have port rx_data, input, 8, meaning the received image byte; bit 0 is the lowest pixel address.
REQ-008 SHALL have port ram_we, output, 1, meaning the input-RAM write enable.
REQ-009 SHALL have port ram_addr, output, ADDR_W, meaning the input-RAM address.
REQ-010 SHALL have port ram_wdata, output, 1, meaning the input-RAM write data bit.
REQ-011 SHALL have port core_addr, input, ADDR_W, meaning the read address driven by snn_core.
REQ-012 SHALL have port core_start, output, 1, meaning a one-cycle start pulse to snn_core.
REQ-013 SHALL have port core_done, input, 1, meaning a one-cycle completion strobe from snn_core.
REQ-014 SHALL have port core_digit, input, 4, meaning the classified digit; valid when core_done=1.
REQ-015 SHALL have port tx_rdy, input, 1, meaning the UART transmitter is idle.
REQ-016 SHALL have port tx_start, output, 1, meaning a one-cycle transmit request.
REQ-017 SHALL have port tx_data, output, 8, meaning the result byte, {4'h0, digit}.
REQ-018 SHALL have port led, output, 8, meaning the last result, {4'h0, digit}.
REQ-019 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-020 SHALL have port ovf, output, 1, meaning a sticky flag set when a byte is dropped.

Function
REQ-021 SHALL implement the states IDLE, SHIFT, WAIT_BYTE, START, RUN and SEND.
REQ-022 IDLE or WAIT_BYTE with rx_rdy=1: SHALL capture rx_data into an 8-bit shift register and enter SHIFT on the next cycle.
REQ-023 SHIFT: SHALL run for exactly 8 cycles with ram_we=1, ram_addr=bit_cnt and ram_wdata=shreg[0]; each cycle SHALL shift shreg right by one and increment bit_cnt.
REQ-024 After 8 SHIFT cycles: if bit_cnt has reached NUM_BITS, SHALL go to START, otherwise to WAIT_BYTE.
REQ-025 ram_addr SHALL equal bit_cnt during SHIFT and core_addr in all other states.
REQ-026 ram_we SHALL be 0 outside SHIFT.
REQ-027 START: SHALL assert core_start for exactly one cycle, then go to RUN.
REQ-028 RUN: on core_done=1, SHALL register core_digit into tx_data and led, then go to SEND.
REQ-029 SEND: SHALL assert tx_start for one cycle in the first cycle in which tx_rdy=1, then go to IDLE and clear bit_cnt to 0.
REQ-030 rx_rdy in SHIFT, START, RUN or SEND SHALL drop the byte, set ovf, and leave the state and bit_cnt unchanged.
REQ-031 ovf SHALL clear only on reset.
REQ-032 core_done outside RUN SHALL be ignored.
REQ-033 Latency: the last rx_rdy to core_start SHALL be 10 cycles (capture, 8 shifts, START).
REQ-034 Latency: core_done to tx_start SHALL be 1 cycle when tx_rdy=1.
REQ-035 bit_cnt SHALL be ADDR_W+1 bits wide and SHALL never wrap within an image.
REQ-036 The loader SHALL have no timeout: a partial image waits in WAIT_BYTE indefinitely.

Reset
REQ-037 When rst=1, SHALL asynchronously set state=IDLE, bit_cnt=0, shreg=0, tx_data=0, led=0 and ovf=0.
REQ-038 When rst=1, SHALL drive core_start=0, tx_start=0, ram_we=0, busy=0 and ram_wdata=0.
REQ-039 Reset asserted mid-load or mid-run SHALL abandon the image.
REQ-040 After reset, the next rx_rdy SHALL be written at address 0.

Verification
REQ-041 Directed test: send 98 bytes of 8'hA5 -> RAM addresses 0..783 hold the pattern 1,0,1,0,0,1,0,1 per byte (LSB first), and core_start pulses once, 10 cycles after the 98th rx_rdy.
REQ-042 Directed test: in RUN, drive core_done=1 with core_digit=4'd7 and tx_rdy=1 -> tx_start pulses on the next cycle, tx_data=8'h07, led=8'h07, and the block returns to IDLE.
REQ-043 Directed test: in SEND, hold tx_rdy=0 for 50 cycles -> no tx_start until tx_rdy rises, then exactly one pulse.
REQ-044 Directed test: assert rx_rdy during SHIFT and during RUN -> ovf=1, bit_cnt unaffected, and the image still completes correctly.
REQ-045 Directed test: assert rst after 40 bytes, then send a full 98 bytes -> the first new bit is at address 0, core_start fires once, and led=0 until the result arrives.
REQ-046 Directed test: outside SHIFT, drive core_addr=10'h123 -> ram_addr=10'h123 and ram_we=0.

Source files
------------

// File: rtl/snn_load_ctrl_if.sv
// Signal bundle between the image loader and its UART, input RAM and SNN core neighbours.
// The master side is the loader; the slave side is the surrounding datapath.
interface snn_load_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wdata;
    logic [ADDR_W-1:0] core_addr;
    logic              core_start;
    logic              core_done;
    logic [3:0]        core_digit;
    logic              tx_rdy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [7:0]        led;
    logic              busy;
    logic              ovf;

    modport master (
        input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
        output ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data, led, busy, ovf
    );

    modport slave (
        output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
        input  ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data, led, busy, ovf
    );
endinterface

// File: rtl/snn_load_ctrl.sv
// Loads a bit-serial image from UART bytes into the SNN input RAM, starts the core,
// and returns the classified digit over UART and on the LEDs.
module snn_load_ctrl #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    snn_load_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT_BYTE,
        START,
        RUN,
        SEND
    } state_t;

    // bit_cnt is the address of the bit being written; the image ends after this one.
    localparam logic [ADDR_W:0] LAST_BIT = (ADDR_W + 1)'(NUM_BITS - 1);

    state_t            state;
    logic [ADDR_W:0]   bit_cnt;
    logic [7:0]        shreg;
    logic              core_start_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        led_q;
    logic              ovf_q;

    logic              in_shift;
    logic              can_accept;

    assign in_shift   = (state == SHIFT);
    assign can_accept = (state == IDLE) || (state == WAIT_BYTE);

    // NOTE: every register below uses <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            core_start_q <= 1'b0;
            tx_data_q    <= '0;
            led_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            core_start_q <= 1'b0;

            // A byte arriving while the loader cannot take it is lost for good.
            if (bus.rx_rdy && !can_accept) begin
                ovf_q <= 1'b1;
            end

            case (state)
                IDLE, WAIT_BYTE: begin
                    if (bus.rx_rdy) begin
                        shreg <= bus.rx_data;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + (ADDR_W + 1)'(1);
                    // Bytes land on 8-bit boundaries, so the low bits mark the byte end.
                    if (bit_cnt[2:0] == 3'd7) begin
                        state <= (bit_cnt == LAST_BIT) ? START : WAIT_BYTE;
                    end
                end

                START: begin
                    core_start_q <= 1'b1;
                    state        <= RUN;
                end

                RUN: begin
                    if (bus.core_done) begin
                        tx_data_q <= {4'h0, bus.core_digit};
                        led_q     <= {4'h0, bus.core_digit};
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (bus.tx_rdy) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // The RAM port belongs to the loader only while shifting; otherwise the core reads it.
    assign bus.ram_we     = in_shift;
    assign bus.ram_addr   = in_shift ? bit_cnt[ADDR_W-1:0] : bus.core_addr;
    assign bus.ram_wdata  = in_shift & shreg[0];

    assign bus.core_start = core_start_q;
    // tx_start follows tx_rdy combinationally in SEND so the result leaves one cycle after core_done.
    assign bus.tx_start   = (state == SEND) & bus.tx_rdy;
    assign bus.tx_data    = tx_data_q;
    assign bus.led        = led_q;
    assign bus.busy       = (state != IDLE);
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_snn_load_ctrl.sv
// Directed bench for snn_load_ctrl: image load, start latency, result send, overflow and reset abort.
module tb_snn_load_ctrl;
    localparam int NB     = 784;
    localparam int NBYTES = NB / 8;

    logic clk;
    logic rst;

    snn_load_ctrl_if #(.ADDR_W(10)) bus ();

    snn_load_ctrl #(
        .NUM_BITS(NB),
        .ADDR_W  (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Observers: RAM image, pulse counters and the edge at which core_start was seen.
    logic mem [0:1023];
    int   cyc     = 0;
    int   wr_cnt  = 0;
    int   cs_cnt  = 0;
    int   cs_edge = 0;
    int   tx_cnt  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.core_start) begin
            cs_cnt  <= cs_cnt + 1;
            cs_edge <= cyc;
        end
        if (bus.tx_start) tx_cnt <= tx_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int passed = 0;
    int last_rx;
    int base_tx;
    int base_wr;
    logic [7:0] img [NBYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One byte: strobe, then 8 shift cycles; optionally a stray strobe mid-shift.
    task automatic send_byte(input logic [7:0] b, input bit inject, input bit first);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        last_rx     = cyc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (first && i == 0) begin
                check("first_we", bus.ram_we, 1);
                check("first_addr", bus.ram_addr, 0);
            end
            bus.rx_rdy  = inject && (i == 3);
            bus.rx_data = 8'hFF;
        end
        @(negedge clk);
    endtask

    task automatic send_image(input bit inject);
        int base_cs;
        int errs;
        base_cs = cs_cnt;
        base_wr = wr_cnt;
        for (int k = 0; k < NBYTES; k++) send_byte(img[k], inject && (k == 5), k == 0);
        for (int t = 0; t < 20; t++) begin
            if (cs_cnt != base_cs) break;
            @(negedge clk);
        end
        check("core_start_count", cs_cnt - base_cs, 1);
        check("start_latency", cs_edge - last_rx, 10);
        check("write_count", wr_cnt - base_wr, NB);
        errs = 0;
        for (int i = 0; i < NB; i++) if (mem[i] !== img[i / 8][i % 8]) errs++;
        check("ram_image", errs, 0);
        check("busy_in_run", bus.busy, 1);
    endtask

    task automatic finish_run(input logic [3:0] digit, input string tag);
        base_tx = tx_cnt;
        @(negedge clk);
        bus.core_done  = 1'b1;
        bus.core_digit = digit;
        bus.tx_rdy     = 1'b1;
        @(negedge clk);
        bus.core_done  = 1'b0;
        check({tag, "_tx_start"}, bus.tx_start, 1);
        check({tag, "_tx_data"}, bus.tx_data, {4'h0, digit});
        check({tag, "_led"}, bus.led, {4'h0, digit});
        @(negedge clk);
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_tx_count"}, tx_cnt - base_tx, 1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.rx_rdy     = 1'b0;
        bus.rx_data    = 8'h00;
        bus.core_addr  = 10'h123;
        bus.core_done  = 1'b0;
        bus.core_digit = 4'h0;
        bus.tx_rdy     = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", bus.busy, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_led", bus.led, 8'h00);
        check("rst_ovf", bus.ovf, 0);
        check("rst_ram_addr", bus.ram_addr, 10'h123);
        rst = 1'b0;

        // core_done outside RUN is ignored
        @(negedge clk);
        bus.core_done  = 1'b1;
        bus.core_digit = 4'd3;
        @(negedge clk);
        bus.core_done  = 1'b0;
        check("idle_done_led", bus.led, 8'h00);
        check("idle_done_busy", bus.busy, 0);

        // Image of 0xA5 bytes, then digit 7 with transmitter ready
        for (int k = 0; k < NBYTES; k++) img[k] = 8'hA5;
        send_image(1'b0);
        check("run_ram_addr", bus.ram_addr, 10'h123);
        check("run_ram_we", bus.ram_we, 0);
        finish_run(4'd7, "a");
        check("a_ovf", bus.ovf, 0);

        // Transmitter busy for 50 cycles in SEND
        for (int k = 0; k < NBYTES; k++) img[k] = 8'((k * 29) + 17);
        bus.tx_rdy = 1'b0;
        send_image(1'b0);
        base_tx = tx_cnt;
        @(negedge clk);
        bus.core_done  = 1'b1;
        bus.core_digit = 4'd9;
        @(negedge clk);
        bus.core_done  = 1'b0;
        repeat (50) @(negedge clk);
        check("hold_tx_count", tx_cnt - base_tx, 0);
        check("hold_busy", bus.busy, 1);
        check("hold_led", bus.led, 8'h09);
        bus.tx_rdy = 1'b1;
        #1;
        check("hold_tx_start", bus.tx_start, 1);
        @(negedge clk);
        check("hold_idle", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("hold_tx_once", tx_cnt - base_tx, 1);

        // Dropped bytes during SHIFT and RUN
        for (int k = 0; k < NBYTES; k++) img[k] = ~8'(k);
        send_image(1'b1);
        check("ovf_shift", bus.ovf, 1);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h55;
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
        check("ovf_run_busy", bus.busy, 1);
        check("ovf_run_no_write", wr_cnt - base_wr, NB);
        finish_run(4'd2, "c");
        check("ovf_sticky", bus.ovf, 1);

        // Reset after 40 bytes abandons the image
        for (int k = 0; k < 40; k++) send_byte(8'h81, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_ovf", bus.ovf, 0);
        check("abort_led", bus.led, 8'h00);
        check("abort_tx_data", bus.tx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NBYTES; k++) img[k] = 8'(k) ^ 8'h5A;
        send_image(1'b0);
        check("abort_led_before", bus.led, 8'h00);
        finish_run(4'd5, "d");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
